// File: rtl/path_pkg.sv
// rtl/path_pkg.sv - shared grid geometry, FSM states and node helpers
package path_pkg;

  localparam int N      = 3;
  localparam int NODE_W = 4;
  localparam int CELLS  = N * N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Flat cell index: row sits in the low node bits, column in the high bits.
  function automatic logic [NODE_W-1:0] node_idx(input logic [NODE_W-1:0] node);
    logic [NODE_W-1:0] row;
    logic [NODE_W-1:0] col;
    row = {2'b00, node[1:0]};
    col = {2'b00, node[3:2]};
    return NODE_W'(row * NODE_W'(N) + col);
  endfunction

  // A node is usable when it lies inside the grid and its cell is traversable.
  function automatic logic node_ok(input logic [NODE_W-1:0] node,
                                   input logic [CELLS-1:0]  grid);
    logic ok;
    ok = 1'b0;
    if (({2'b00, node[1:0]} < NODE_W'(N)) && ({2'b00, node[3:2]} < NODE_W'(N)))
      ok = grid[node_idx(node)];
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting after ptr
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] cand;
  logic            hit;

  // Scan upward from ptr+1 with wrap-around; the first active requester wins.
  always_comb begin
    grant = '0;
    id    = '0;
    hit   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!hit && req[cand]) begin
        hit         = 1'b1;
        grant[cand] = 1'b1;
        id          = cand;
      end
    end
  end

endmodule

// File: rtl/path_query_scheduler.sv
// rtl/path_query_scheduler.sv - shares one path engine between requesters
module path_query_scheduler
  import path_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 32,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CELLS-1:0]          grid,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NODE_W*NUM_REQ-1:0] req_start,
  input  logic [NODE_W*NUM_REQ-1:0] req_end,
  output logic                      eng_start,
  output logic [CELLS-1:0]          eng_grid,
  output logic [NODE_W-1:0]         eng_start_node,
  output logic [NODE_W-1:0]         eng_end_node,
  input  logic                      eng_done,
  input  logic                      eng_found,
  input  logic [CELLS-1:0]          eng_path,
  input  logic [3:0]                eng_length,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_found,
  output logic [CELLS-1:0]          rsp_path,
  output logic [3:0]                rsp_length,
  output logic                      rsp_err,
  output logic                      rsp_timeout
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, id_q, grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [NODE_W-1:0]  start_q, end_q, sel_start, sel_end;
  logic [CELLS-1:0]   grid_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               endpoints_ok, timed_out;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .id    (grant_id)
  );

  // Pick the granted requester's endpoints out of the packed request buses.
  always_comb begin
    sel_start = '0;
    sel_end   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_start = req_start[NODE_W*i +: NODE_W];
        sel_end   = req_end[NODE_W*i +: NODE_W];
      end
    end
  end

  assign endpoints_ok   = node_ok(start_q, grid_q) && node_ok(end_q, grid_q);
  assign timed_out      = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign eng_start      = (state == ST_LAUNCH);
  assign rsp_valid      = (state == ST_RESP);
  assign eng_grid       = grid_q;
  assign eng_start_node = start_q;
  assign eng_end_node   = end_q;
  assign rsp_id         = id_q;

  // Next-state decode; grants are only offered while idle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        req_ready = grant;
        if (|req_valid) state_nxt = ST_CHECK;
      end
      ST_CHECK:  state_nxt = endpoints_ok ? ST_LAUNCH : ST_RESP;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (eng_done || timed_out) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any query in flight without a response.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Query latches, watchdog and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      start_q     <= '0;
      end_q       <= '0;
      grid_q      <= '0;
      wait_cnt    <= '0;
      rsp_found   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_path    <= '0;
      rsp_length  <= 4'hF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            id_q    <= grant_id;
            rr_ptr  <= grant_id;
            start_q <= sel_start;
            end_q   <= sel_end;
            grid_q  <= grid;
          end
        end
        ST_CHECK: begin
          if (!endpoints_ok) begin
            rsp_err     <= 1'b1;
            rsp_found   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_length  <= 4'hF;
            rsp_path    <= '0;
          end
        end
        ST_LAUNCH: wait_cnt <= '0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (eng_done) begin
            rsp_found   <= eng_found;
            rsp_path    <= eng_path;
            rsp_length  <= eng_length;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
          end else if (timed_out) begin
            rsp_timeout <= 1'b1;
            rsp_found   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_length  <= 4'hF;
            rsp_path    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/path_query_scheduler.md
Name: path_query_scheduler

Overview:
- Shares one grid shortest-path engine (3x3 grid, 4-bit node IDs) between NUM_REQ requesters.
- Arbitrates requests round-robin and validates each query's endpoints against the grid.
- Launches the engine, applies a watchdog timeout, and returns one tagged response per accepted request.
- Sits between the requester clients and the path-finding datapath; the engine is never driven directly by clients.

Parameters:
- NUM_REQ, 4, number of requesters.
- N, 3, grid side length; grid holds N*N cells.
- TIMEOUT, 32, maximum WAIT cycles before the query is aborted.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- grid  in  N*N  cell map; bit row*N+col = 1 means the cell is traversable.
- req_valid  in  NUM_REQ  per-requester query valid.
- req_ready  out  NUM_REQ  one-hot accept; a handshake completes when req_valid[i] & req_ready[i].
- req_start  in  4*NUM_REQ  packed start nodes; slice i is [4i+3:4i].
- req_end  in  4*NUM_REQ  packed end nodes.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_grid  out  N*N  grid latched at accept.
- eng_start_node, eng_end_node  out  4  latched endpoints; stable from LAUNCH until leaving WAIT.
- eng_done  in  1  engine completion pulse.
- eng_found  in  1  engine path-exists flag.
- eng_path  in  N*N  engine path mask.
- eng_length  in  4  engine path length.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the response.
- rsp_found  out  1  a path was found.
- rsp_path  out  N*N  path mask.
- rsp_length  out  4  path length; 4'hF when no path.
- rsp_err  out  1  query rejected by validation.
- rsp_timeout  out  1  engine did not finish in time.

Behaviour:
- Node encoding: row = node[1:0], col = node[3:2]. A node is valid when row<N, col<N and grid[row*N+col]=1.
- Reset values:
  - FSM=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - eng_start=0.
  - rsp_valid=0, rsp_found=0, rsp_err=0, rsp_timeout=0.
  - rsp_path=0, rsp_length=4'hF, rsp_id=0.
  - All latches cleared.
- Reset mid-operation aborts the query with no response. A late eng_done arriving after reset is ignored.
- FSM states: IDLE, CHECK, LAUNCH, WAIT, RESP.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first valid requester searching from rr_ptr+1 with wrap-around.
  - req_ready is all-zero outside IDLE and when no request is valid.
  - On handshake: latch id, start, end and grid; rr_ptr<=id; go to CHECK.
- CHECK (1 cycle):
  - If either endpoint is invalid: rsp_err=1, rsp_found=0, rsp_length=4'hF, rsp_path=0; go to RESP.
  - Otherwise go to LAUNCH.
  - start==end is valid and is passed to the engine.
- LAUNCH (1 cycle): eng_start=1; clear wait counter; go to WAIT.
- WAIT:
  - Counter width is $clog2(TIMEOUT+1); the counter increments each cycle.
  - If eng_done: capture eng_found, eng_path and eng_length; set err=0, timeout=0; go to RESP.
  - Else if counter==TIMEOUT-1: rsp_timeout=1, found=0, length=4'hF, path=0; go to RESP.
  - If eng_done and the timeout coincide, eng_done wins.
- RESP: rsp_valid=1 and all rsp_* are held stable until rsp_ready; on handshake go to IDLE, with rsp_valid low next cycle.
- eng_done outside WAIT is ignored.
- Only one query is in flight. A requester's req_valid may stay high across its own response; it is re-arbitrated fairly behind other requesters.
- Latency, with accept at cycle 0:
  - Invalid query: rsp_valid at cycle 2.
  - Valid query: eng_start at cycle 2; eng_done seen at cycle k gives rsp_valid at cycle k+1.
  - Timeout: rsp_valid at cycle 3+TIMEOUT.
- Grid or request changes after accept do not affect the in-flight query.

Decomposition:
- Package path_pkg holds:
  - N and NODE_W=4.
  - The FSM state enum.
  - Function node_ok(node, grid).
  - Function node_idx(node) = row*N+col.
- Sub-module rr_arbiter (parameter NUM_REQ): inputs req and ptr; outputs one-hot grant and encoded id. Purely combinational.
- The FSM, latches and timer stay in the top module.

Test Plan:
- Single query, grid=9'h1FF, start=0x0, end=0xA, engine returns done after 5 cycles with found=1, length=4, path=9'h1C9 -> rsp_valid at cycle 8, id=0, found=1, length=4, err=0, timeout=0.
- All 4 requesters valid continuously -> grants follow the order 0,1,2,3,0; each req_ready is one cycle wide and one-hot; no starvation.
- start=0x3 (row 3 out of range), or end on a blocked cell (grid bit=0) -> rsp_err=1, found=0, length=4'hF at cycle 2; eng_start never asserted.
- Engine never asserts done, TIMEOUT=32 -> rsp_timeout=1, found=0 at cycle 35; a later stray eng_done is ignored and the next query proceeds normally.
- eng_done at the exact timeout cycle -> timeout=0 and engine results are returned. rsp_ready held low for 10 cycles -> rsp_* stay stable and no new req_ready is issued.
- reset asserted during WAIT -> next cycle: IDLE, rsp_valid=0, eng_start=0, rr_ptr reset so requester 0 wins the next arbitration.
